sd_block_cache: RTL and testbench

Single-block write-back cache between a byte-wide host port and `sd_controller`. It holds one SD block in a local buffer, so host byte reads and writes inside the same block complete in one cycle without SD traffic. On a miss it writes back the dirty block, then fills the new block, using the controller's `rd`/`wr`/`ain`/`din_ready`/`dout_valid`/`ready` handshake. It sits directly upstream of `sd_controller`; its `sd_*` ports connect 1:1 to that block.

---
 rtl/sd_block_cache.sv | 197 +++++++++++++++++++
 tb/tb_sd_block_cache.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_block_cache.sv
// Single-block write-back cache between a byte-wide host port and sd_controller.
// One SD block is buffered locally; misses write back a dirty block, then refill.
module sd_block_cache #(
  parameter int BLOCK_BITS = 9
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] h_addr,
  input  logic        h_rd,
  input  logic        h_wr,
  input  logic [7:0]  h_wdata,
  input  logic        flush,
  output logic [7:0]  h_rdata,
  output logic        h_ack,
  output logic        h_busy,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic [31:0] sd_ain,
  output logic [7:0]  sd_din,
  input  logic        sd_din_ready,
  input  logic [7:0]  sd_dout,
  input  logic        sd_dout_valid,
  input  logic        sd_ready
);

  localparam int NBYTES = 1 << BLOCK_BITS;
  localparam int TAG_W  = 32 - BLOCK_BITS;
  localparam logic [BLOCK_BITS:0] LAST_IDX = (BLOCK_BITS + 1)'(NBYTES - 1);

  typedef enum logic [3:0] {
    INIT, IDLE, HIT, WB_CMD, WB_DATA, WB_DONE, FILL_CMD, FILL_DATA, FILL_DONE
  } state_t;

  state_t                state;
  logic                  valid, dirty;
  logic                  flush_pend;
  logic                  wb_flush;   // write-back was started by a flush, not a miss
  logic                  seen_low;   // sd_ready seen low since the last command
  logic                  req_wr;
  logic [TAG_W-1:0]      tag, req_tag, h_tag;
  logic [BLOCK_BITS-1:0] req_off;
  logic [7:0]            req_data;
  logic [BLOCK_BITS:0]   idx, idx_nxt;
  logic                  h_hit;

  logic [7:0]            mem [NBYTES];
  logic                  mem_we;
  logic [BLOCK_BITS-1:0] mem_wa;
  logic [7:0]            mem_wd;

  assign h_tag   = h_addr[31:BLOCK_BITS];
  assign h_hit   = valid && (tag == h_tag);
  assign idx_nxt = idx + 1'b1;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    mem_we = 1'b0;
    mem_wa = idx[BLOCK_BITS-1:0];
    mem_wd = sd_dout;
    if (state == FILL_DATA && sd_dout_valid) begin
      mem_we = 1'b1;
    end else if (state == HIT && req_wr) begin
      mem_we = 1'b1;
      mem_wa = req_off;
      mem_wd = req_data;
    end
  end

  // NOTE: the block buffer has no reset; its contents are meaningless until a fill sets valid.
  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // NOTE: sequential state uses non-blocking assignments only; later assignments in the block win.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= INIT;
      valid      <= 1'b0;
      dirty      <= 1'b0;
      flush_pend <= 1'b0;
      wb_flush   <= 1'b0;
      seen_low   <= 1'b0;
      req_wr     <= 1'b0;
      req_tag    <= '0;
      req_off    <= '0;
      req_data   <= '0;
      tag        <= '0;
      idx        <= '0;
      h_rdata    <= '0;
      h_ack      <= 1'b0;
      h_busy     <= 1'b1;
      sd_rd      <= 1'b0;
      sd_wr      <= 1'b0;
      sd_ain     <= '0;
      sd_din     <= '0;
    end else begin
      h_ack <= 1'b0;
      sd_rd <= 1'b0;
      sd_wr <= 1'b0;
      if (!sd_ready) seen_low <= 1'b1;

      unique case (state)
        INIT: if (sd_ready) begin
          state  <= IDLE;
          h_busy <= 1'b0;
        end

        IDLE: if (h_wr || h_rd) begin
          req_wr   <= h_wr;
          req_tag  <= h_tag;
          req_off  <= h_addr[BLOCK_BITS-1:0];
          req_data <= h_wdata;
          h_busy   <= 1'b1;
          if (h_hit) begin
            state <= HIT;
          end else if (valid && dirty) begin
            state    <= WB_CMD;
            wb_flush <= 1'b0;
            sd_wr    <= 1'b1;
            sd_ain   <= {{BLOCK_BITS{1'b0}}, tag};
            sd_din   <= mem[0];
            idx      <= '0;
            seen_low <= 1'b0;
          end else begin
            state    <= FILL_CMD;
            sd_rd    <= 1'b1;
            sd_ain   <= {{BLOCK_BITS{1'b0}}, h_tag};
            idx      <= '0;
            seen_low <= 1'b0;
          end
        end else if (flush_pend) begin
          flush_pend <= 1'b0;
          if (valid && dirty) begin
            state    <= WB_CMD;
            h_busy   <= 1'b1;
            wb_flush <= 1'b1;
            sd_wr    <= 1'b1;
            sd_ain   <= {{BLOCK_BITS{1'b0}}, tag};
            sd_din   <= mem[0];
            idx      <= '0;
            seen_low <= 1'b0;
          end
        end

        HIT: begin
          if (req_wr) dirty   <= 1'b1;
          else        h_rdata <= mem[req_off];
          h_ack  <= 1'b1;
          h_busy <= 1'b0;
          state  <= IDLE;
        end

        WB_CMD: state <= WB_DATA;

        WB_DATA: if (sd_din_ready) begin
          idx    <= idx_nxt;
          sd_din <= mem[idx_nxt[BLOCK_BITS-1:0]];
          if (idx == LAST_IDX) state <= WB_DONE;
        end

        WB_DONE: if (sd_ready && seen_low) begin
          dirty <= 1'b0;
          if (wb_flush) begin
            state  <= IDLE;
            h_busy <= 1'b0;
          end else begin
            state    <= FILL_CMD;
            sd_rd    <= 1'b1;
            sd_ain   <= {{BLOCK_BITS{1'b0}}, req_tag};
            idx      <= '0;
            seen_low <= 1'b0;
          end
        end

        FILL_CMD: state <= FILL_DATA;

        FILL_DATA: if (sd_dout_valid) begin
          idx <= idx_nxt;
          if (idx == LAST_IDX) state <= FILL_DONE;
        end

        FILL_DONE: if (sd_ready && seen_low) begin
          valid <= 1'b1;
          dirty <= 1'b0;
          tag   <= req_tag;
          state <= HIT;
        end

        default: state <= INIT;
      endcase

      // A flush pulse is remembered in any state, including the cycle a request is accepted.
      if (flush) flush_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sd_block_cache.sv
// Scoreboard bench for sd_block_cache (BLOCK_BITS=4) with a behavioural SD controller model.
// Host reads, SD commands and write-back bytes are predicted by a reference cache model.
module tb_sd_block_cache;

  localparam int BB    = 4;
  localparam int NB    = 1 << BB;
  localparam int BOUND = 3000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] h_addr = '0;
  logic        h_rd = 1'b0, h_wr = 1'b0, flush = 1'b0;
  logic [7:0]  h_wdata = '0;
  logic [7:0]  h_rdata;
  logic        h_ack, h_busy, sd_rd, sd_wr;
  logic [31:0] sd_ain;
  logic [7:0]  sd_din;
  logic        sd_din_ready = 1'b0, sd_dout_valid = 1'b0, sd_ready = 1'b0;
  logic [7:0]  sd_dout = '0;

  sd_block_cache #(.BLOCK_BITS(BB)) dut (
    .clock(clock), .reset(reset),
    .h_addr(h_addr), .h_rd(h_rd), .h_wr(h_wr), .h_wdata(h_wdata), .flush(flush),
    .h_rdata(h_rdata), .h_ack(h_ack), .h_busy(h_busy),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ain(sd_ain), .sd_din(sd_din),
    .sd_din_ready(sd_din_ready), .sd_dout(sd_dout),
    .sd_dout_valid(sd_dout_valid), .sd_ready(sd_ready)
  );

  always #5 clock = ~clock;

  typedef struct { logic [7:0] data; int acc; logic chk_lat; } host_exp_t;
  typedef struct { logic is_wr; logic [31:0] blk; } cmd_exp_t;

  host_exp_t  exp_host[$];
  cmd_exp_t   exp_cmd[$];
  logic [7:0] exp_wb[$];
  logic [7:0] ref_mem [int];
  logic [7:0] disk [int];

  int checks = 0, failures = 0;
  int cyc = 0, cmd_count = 0, fill_beats = 0;

  // Reference cache state
  logic        cv = 1'b0, cd = 1'b0;
  logic [31:0] ct = '0;
  logic [7:0]  last_rd = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] dflt(input int a);
    return 8'((a * 29 + 7) ^ (a >> 3));
  endfunction

  function automatic logic [7:0] ref_get(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic [7:0] disk_get(input int a);
    return disk.exists(a) ? disk[a] : dflt(a);
  endfunction

  task automatic push_wb(input logic [31:0] blk);
    exp_cmd.push_back('{is_wr: 1'b1, blk: blk});
    for (int i = 0; i < NB; i++) exp_wb.push_back(ref_get(int'(blk) * NB + i));
  endtask

  task automatic wait_not_busy();
    int n = 0;
    while (h_busy !== 1'b0 && n < BOUND) begin @(negedge clock); n++; end
    check("busy_timeout", n < BOUND, 1);
  endtask

  // Drives one host request at a negedge, predicting its SD traffic and result first.
  task automatic issue(input logic wr, input logic rd, input logic [31:0] addr,
                       input logic [7:0] d, input logic fl);
    logic [31:0] t;
    logic        hit;
    host_exp_t   e;
    wait_not_busy();
    t   = addr >> BB;
    hit = cv && (ct == t);
    if (!hit) begin
      if (cv && cd) push_wb(ct);
      exp_cmd.push_back('{is_wr: 1'b0, blk: t});
      cv = 1'b1; ct = t; cd = 1'b0;
    end
    if (wr) begin
      cd = 1'b1;
      ref_mem[int'(addr)] = d;
      e.data = last_rd;
    end else begin
      e.data  = ref_get(int'(addr));
      last_rd = e.data;
    end
    if (fl && cd) begin push_wb(ct); cd = 1'b0; end
    e.acc = cyc + 1;
    e.chk_lat = hit;
    exp_host.push_back(e);
    h_addr = addr; h_wdata = d; h_wr = wr; h_rd = rd; flush = fl;
    @(negedge clock);
    h_wr = 1'b0; h_rd = 1'b0; flush = 1'b0;
  endtask

  task automatic pulse_flush();
    wait_not_busy();
    if (cv && cd) begin push_wb(ct); cd = 1'b0; end
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_host.size() != 0 || exp_cmd.size() != 0 || exp_wb.size() != 0 ||
            h_busy !== 1'b0 || sd_ready !== 1'b1) && n < BOUND) begin
      @(negedge clock); n++;
    end
    check("done_timeout", n < BOUND, 1);
  endtask

  // Host-side monitor: pops the scoreboard on every h_ack.
  initial forever begin
    @(negedge clock);
    if (reset && h_ack) begin
      host_exp_t e;
      check("ack_expected", exp_host.size() > 0, 1);
      check("busy_at_ack", h_busy, 0);
      if (exp_host.size() > 0) begin
        e = exp_host.pop_front();
        check("h_rdata", h_rdata, e.data);
        if (e.chk_lat) check("hit_latency", cyc - e.acc, 1);
      end
    end
  end

  // Controller model: serves one block command; returns early if reset drops.
  task automatic serve();
    logic        is_wr;
    logic [31:0] blk;
    cmd_exp_t    e;
    cmd_count++;
    is_wr = sd_wr;
    blk   = sd_ain;
    check("cmd_exclusive", sd_rd & sd_wr, 0);
    check("cmd_expected", exp_cmd.size() > 0, 1);
    if (exp_cmd.size() > 0) begin
      e = exp_cmd.pop_front();
      check("cmd_kind", is_wr, e.is_wr);
      check("sd_ain", blk, e.blk);
    end
    sd_ready = 1'b0;
    for (int i = 0; i < NB; i++) begin
      @(negedge clock);
      if (!reset) return;
      sd_din_ready = 1'b0; sd_dout_valid = 1'b0;
      if (i == 0) check("cmd_pulse_width", sd_rd | sd_wr, 0);
      if (i % 4 == 3) begin @(negedge clock); if (!reset) return; end
      check("ain_hold", sd_ain, blk);
      if (is_wr) begin
        sd_din_ready = 1'b1;
        disk[int'(blk) * NB + i] = sd_din;
        check("wb_expected", exp_wb.size() > 0, 1);
        if (exp_wb.size() > 0) check("wb_byte", sd_din, exp_wb.pop_front());
      end else begin
        sd_dout = disk_get(int'(blk) * NB + i);
        sd_dout_valid = 1'b1;
        fill_beats++;
      end
    end
    @(negedge clock); if (!reset) return;
    sd_din_ready = 1'b0; sd_dout_valid = 1'b0;
    // Stray strobe after the full count must be ignored.
    @(negedge clock); if (!reset) return;
    sd_dout = 8'hEE;
    if (is_wr) sd_din_ready = 1'b1; else sd_dout_valid = 1'b1;
    @(negedge clock); if (!reset) return;
    sd_din_ready = 1'b0; sd_dout_valid = 1'b0;
    @(negedge clock); if (!reset) return;
    sd_ready = 1'b1;
  endtask

  initial begin
    int init_cnt = 0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        sd_ready = 1'b0; sd_din_ready = 1'b0; sd_dout_valid = 1'b0;
        init_cnt = 5;
      end else if (init_cnt > 0) begin
        init_cnt--;
        if (init_cnt == 0) sd_ready = 1'b1;
      end else if (sd_rd || sd_wr) begin
        serve();
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_h_rdata"}, h_rdata, 0);
    check({tag, "_h_ack"},   h_ack,   0);
    check({tag, "_h_busy"},  h_busy,  1);
    check({tag, "_sd_rd"},   sd_rd,   0);
    check({tag, "_sd_wr"},   sd_wr,   0);
    check({tag, "_sd_ain"},  sd_ain,  0);
    check({tag, "_sd_din"},  sd_din,  0);
  endtask

  initial begin
    int n, fb0, c0;
    repeat (3) @(negedge clock);
    check_reset_outputs("rst");
    #2 reset = 1'b1;

    // Cold read: one fill of block 0x3
    issue(1'b0, 1'b1, 32'h35, 8'h00, 1'b0);
    wait_done();

    // Hits: no SD traffic, one-cycle ack
    c0 = cmd_count;
    issue(1'b1, 1'b0, 32'h37, 8'hA5, 1'b0);
    issue(1'b0, 1'b1, 32'h37, 8'h00, 1'b0);
    issue(1'b0, 1'b1, 32'h3F, 8'h00, 1'b0);
    wait_done();
    check("hits_no_sd", cmd_count - c0, 0);

    // Dirty eviction: write back 0x3, fill 0x10
    issue(1'b0, 1'b1, 32'h100, 8'h00, 1'b0);
    wait_done();

    // Flush of a dirty block, then of a clean one
    issue(1'b1, 1'b0, 32'h100, 8'h11, 1'b0);
    pulse_flush();
    wait_done();
    c0 = cmd_count;
    pulse_flush();
    repeat (10) @(negedge clock);
    check("clean_flush_no_sd", cmd_count - c0, 0);
    check("clean_flush_idle", h_busy, 0);

    // Simultaneous read and write on a hit acts as a write
    issue(1'b1, 1'b1, 32'h10A, 8'h3C, 1'b0);
    issue(1'b0, 1'b1, 32'h10A, 8'h00, 1'b0);
    wait_done();

    // Reset in the middle of a fill: outputs clear at once, request dropped
    fb0 = fill_beats;
    issue(1'b0, 1'b1, 32'h205, 8'h00, 1'b0);
    n = 0;
    while (fill_beats < fb0 + 5 && n < BOUND) begin @(negedge clock); n++; end
    check("fill_reach_timeout", n < BOUND, 1);
    #2 reset = 1'b0;
    #1 check_reset_outputs("mid_rst");
    exp_host.delete(); exp_cmd.delete(); exp_wb.delete();
    cv = 1'b0; cd = 1'b0; last_rd = '0;
    repeat (4) @(negedge clock);
    #2 reset = 1'b1;
    issue(1'b0, 1'b1, 32'h205, 8'h00, 1'b0);
    wait_done();

    // Flush arriving with a missing write: fill, ack, then write-back
    issue(1'b1, 1'b0, 32'h3F1, 8'h77, 1'b1);
    wait_done();
    issue(1'b0, 1'b1, 32'h3F1, 8'h00, 1'b0);
    wait_done();

    check("end_host_q", exp_host.size(), 0);
    check("end_cmd_q", exp_cmd.size(), 0);
    check("end_wb_q", exp_wb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
